tdm_demux_1x4: RTL
==================

// Module: tdm_demux_1x4
// PURPOSE
//   Receive end of the 4:1 TDM lane mux: deserialises one serial TDM stream back into 4 parallel lanes.
//   Frame = 4 slots (lane 0..3), each slot SLOT_BITS bits, MSB first; fsync marks bit 0 of slot 0.
//   Sits after the mux/serial link; feeds per-lane consumers with registered words plus 1-cycle valid strobes.
// PARAMETERS
//   LANE_W   8   data bits per lane/slot (>=2)
//   SLOT_BITS    = LANE_W (LANE_W+1 when TDM_PARITY_EN defined); derived localparam, not overridable
// PORTS
//   clk         in   1          rising-edge clock, single domain
//   rst_n       in   1          synchronous reset, active-low (sampled on clk rise)
//   enable      in   1          1 = consume din this cycle; 0 = freeze all state
//   din         in   1          serial TDM data bit
//   fsync       in   1          frame sync, high with first bit of slot 0
//   y           out  4*LANE_W   lane words; lane k at y[k*LANE_W +: LANE_W]
//   valid       out  4          valid[k] 1-cycle pulse when y lane k updated
//   frame_done  out  1          1-cycle pulse with valid[3]
//   locked      out  1          1 while in RUN
//   sync_err    out  1          1-cycle pulse on misplaced fsync
//   par_err     out  4          per-lane parity error pulse (0 when TDM_PARITY_EN undefined)
// BEHAVIOUR
//   - Reset (rst_n=0 at clk rise): state IDLE, bit_cnt=0, slot_cnt=0, shift reg=0, y=0, valid=0,
//     frame_done=0, locked=0, sync_err=0, par_err=0. Reset mid-frame discards partial data.
//   - FSM IDLE: din ignored until enable&fsync; that edge samples din as bit 0 of slot 0, bit_cnt->1, -> RUN.
//   - FSM RUN: each enable=1 edge shifts din in (MSB first), bit_cnt++; locked=1.
//     At edge sampling bit SLOT_BITS-1: y lane slot_cnt <= data bits, valid[slot_cnt]=1 for that cycle only,
//     bit_cnt->0, slot_cnt++ (wraps 3->0). Latency: word/valid visible right after edge of its last bit.
//     frame_done pulses together with valid[3]. Other lanes' y hold.
//   - Free-running: absent fsync at frame start is legal; framing continues on count.
//   - fsync in RUN at slot_cnt==0 & bit_cnt==0: normal, no error.
//   - fsync in RUN elsewhere: sync_err pulse, partial slot dropped (no y/valid for it), din taken as
//     bit 0 of slot 0 (realign), bit_cnt->1, slot_cnt->0. If last bit of a slot coincides with misplaced
//     fsync, fsync wins: slot dropped.
//   - enable=0: counters, shift reg, state frozen; fsync/din ignored; all pulse outputs 0; y/locked hold.
//   - All outputs registered; no combinational path input->output.
// CONFIGURATION
//   TDM_PARITY_EN defined: SLOT_BITS=LANE_W+1; last slot bit is even parity over the LANE_W data bits.
//     On slot completion y still updates; par_err[k] pulses with valid[k] if parity mismatch.
//   TDM_PARITY_EN undefined: SLOT_BITS=LANE_W, no parity bit, par_err tied 4'b0000.
// TESTING (LANE_W=8, parity off unless noted)
//   1. rst_n=0 2 cycles, din/fsync toggling -> y=0, valid=0, locked=0, all pulses 0.
//   2. enable=1, fsync with first bit; send A5,3C,F0,0F -> valid 0001/0010/0100/1000 after bits 8/16/24/32,
//      frame_done with 4th, y=32'h0FF03CA5, locked=1.
//   3. As 2 with enable=0 for 5 cycles inside slot 1 -> same y, valid[1] and later strobes delayed 5 cycles.
//   4. fsync at bit 3 of slot 2 -> sync_err 1 cycle, lane 2 y unchanged, next 8 bits land in lane 0.
//   5. rst_n=0 at bit 20 of frame -> all outputs 0, IDLE; bits without fsync ignored; next fsync relocks.
//   6. TDM_PARITY_EN: lane 1 = 3C with parity bit 1 (wrong) -> y lane1=3C, valid[1] and par_err[1] pulse.

Source files
------------

// File: rtl/tdm_demux_1x4.sv
// Receive side of the 4:1 TDM lane link: deserialises one MSB-first serial stream into four lanes.
// Optional per-slot even parity bit is enabled by defining TDM_PARITY_EN.
module tdm_demux_1x4 #(
  parameter int LANE_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                din,
  input  logic                fsync,
  output logic [4*LANE_W-1:0] y,
  output logic [3:0]          valid,
  output logic                frame_done,
  output logic                locked,
  output logic                sync_err,
  output logic [3:0]          par_err
);

`ifdef TDM_PARITY_EN
  localparam int SLOT_BITS = LANE_W + 1;
`else
  localparam int SLOT_BITS = LANE_W;
`endif
  localparam int CNT_W = $clog2(SLOT_BITS);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state_reg;
  logic [CNT_W-1:0]       bit_cnt_reg;
  logic [1:0]             slot_cnt_reg;
  logic [SLOT_BITS-2:0]   shift_reg;
  logic [3:0]             valid_reg;
  logic                   frame_done_reg;
  logic                   locked_reg;
  logic                   sync_err_reg;

  // Current slot as it would look if this cycle's bit is its last one.
  logic [SLOT_BITS-1:0]   slot_word;
  logic [LANE_W-1:0]      slot_data;
  logic                   misplaced;
  logic                   last_bit;
  logic                   slot_done;
  logic [3:0]             lane_sel;

  assign slot_word = {shift_reg, din};
  assign slot_data = slot_word[SLOT_BITS-1 -: LANE_W];
  assign misplaced = (state_reg == RUN) && fsync && ((slot_cnt_reg != 2'd0) || (bit_cnt_reg != '0));
  assign last_bit  = (bit_cnt_reg == CNT_W'(SLOT_BITS - 1));
  assign slot_done = enable && (state_reg == RUN) && !misplaced && last_bit;
  assign lane_sel  = 4'b0001 << slot_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      bit_cnt_reg    <= '0;
      slot_cnt_reg   <= 2'd0;
      shift_reg      <= '0;
      valid_reg      <= 4'b0000;
      frame_done_reg <= 1'b0;
      locked_reg     <= 1'b0;
      sync_err_reg   <= 1'b0;
    end else begin
      valid_reg      <= 4'b0000;
      frame_done_reg <= 1'b0;
      sync_err_reg   <= 1'b0;
      if (enable) begin
        case (state_reg)
          IDLE: begin
            if (fsync) begin
              state_reg    <= RUN;
              locked_reg   <= 1'b1;
              shift_reg    <= slot_word[SLOT_BITS-2:0];
              bit_cnt_reg  <= CNT_W'(1);
              slot_cnt_reg <= 2'd0;
            end
          end
          RUN: begin
            shift_reg <= slot_word[SLOT_BITS-2:0];
            if (misplaced) begin
              // Realign: this bit becomes bit 0 of slot 0, the partial slot is lost.
              sync_err_reg <= 1'b1;
              bit_cnt_reg  <= CNT_W'(1);
              slot_cnt_reg <= 2'd0;
            end else if (last_bit) begin
              valid_reg      <= lane_sel;
              frame_done_reg <= (slot_cnt_reg == 2'd3);
              bit_cnt_reg    <= '0;
              slot_cnt_reg   <= slot_cnt_reg + 2'd1;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [LANE_W-1:0] word_reg;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          word_reg <= '0;
        end else if (slot_done && lane_sel[gi]) begin
          word_reg <= slot_data;
        end
      end
      assign y[gi*LANE_W +: LANE_W] = word_reg;
    end
  endgenerate

`ifdef TDM_PARITY_EN
  logic [3:0] par_err_reg;
  // Even parity: data bits plus parity bit must hold an even number of ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_err_reg <= 4'b0000;
    end else begin
      par_err_reg <= slot_done ? (lane_sel & {4{^slot_word}}) : 4'b0000;
    end
  end
  assign par_err = par_err_reg;
`else
  assign par_err = 4'b0000;
`endif

  assign valid      = valid_reg;
  assign frame_done = frame_done_reg;
  assign locked     = locked_reg;
  assign sync_err   = sync_err_reg;

endmodule
